// File: rtl/wb_interconnect_pkg.sv
// Shared types and constants for the Wishbone B4 interconnect.
package wb_interconnect_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam logic [WB_DW-1:0] WB_DEFAULT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DECERR,
        TOERR
    } state_t;

    // Width of a slave index; a single-slave map still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/wb_interconnect_if.sv
// Wishbone B4 master-side bundle between the CPU and the interconnect.
interface wb_interconnect_if;
    import wb_interconnect_pkg::*;

    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_o;
    logic [WB_DW-1:0] dat_i;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;

    modport master (output adr, dat_o, we, cyc, stb, input  dat_i, ack);
    modport slave  (input  adr, dat_o, we, cyc, stb, output dat_i, ack);

endinterface

// File: rtl/wb_addr_decoder.sv
// Priority base/mask address match; the lowest matching slave index wins.
module wb_addr_decoder
    import wb_interconnect_pkg::*;
#(
    parameter int unsigned               NSLAVES    = 4,
    parameter logic [NSLAVES*WB_AW-1:0]  SLAVE_BASE = '0,
    parameter logic [NSLAVES*WB_AW-1:0]  SLAVE_MASK = '0,
    parameter int unsigned               SEL_W      = sel_width(NSLAVES)
) (
    input  logic [WB_AW-1:0] adr,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    // Scan from the top so the lowest index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((adr & SLAVE_MASK[i*WB_AW +: WB_AW]) == SLAVE_BASE[i*WB_AW +: WB_AW]) begin
                hit = 1'b1;
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Wishbone B4 interconnect: one CPU master to NSLAVES slaves via a base/mask map.
// Optional slave watchdog enabled by defining WB_INTERCONNECT_WATCHDOG_EN.
module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter int unsigned              NSLAVES        = 4,
    parameter logic [NSLAVES*WB_AW-1:0] SLAVE_BASE     = '0,
    parameter logic [NSLAVES*WB_AW-1:0] SLAVE_MASK     = '0,
    parameter logic [WB_DW-1:0]         DEFAULT_DATA   = WB_DEFAULT_DATA,
    parameter int unsigned              TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    wb_interconnect_if.slave           cpu,
    output logic [WB_AW-1:0]           s_adr,
    output logic [WB_DW-1:0]           s_dat_o,
    output logic                       s_we,
    output logic [NSLAVES-1:0]         s_cyc,
    output logic [NSLAVES-1:0]         s_stb,
    input  logic [NSLAVES*WB_DW-1:0]   s_dat_i,
    input  logic [NSLAVES-1:0]         s_ack,
    output logic                       bus_err,
    output logic [WB_AW-1:0]           err_addr
);

    localparam int unsigned SEL_W = sel_width(NSLAVES);

    if (NSLAVES == 0 || NSLAVES > 16 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("wb_interconnect: parameter out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] dec_idx;
    logic             dec_hit;
    logic             req;
    logic             slave_ack;
    logic             wd_expired;
    logic [WB_DW-1:0] slv_dat [NSLAVES];

    assign s_adr   = cpu.adr;
    assign s_dat_o = cpu.dat_o;
    assign s_we    = cpu.we;
    assign req     = cpu.cyc & cpu.stb;

    for (genvar i = 0; i < NSLAVES; i++) begin : g_unpack
        assign slv_dat[i] = s_dat_i[i*WB_DW +: WB_DW];
    end

    wb_addr_decoder #(
        .NSLAVES    (NSLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .SEL_W      (SEL_W)
    ) u_dec (
        .adr (cpu.adr),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // A slave ACK only counts while the CPU still owns the cycle; late ACKs after an abort are dropped.
    assign slave_ack = cpu.cyc & s_ack[sel];

`ifdef WB_INTERCONNECT_WATCHDOG_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state != ACTIVE) begin
            wd_cnt <= '0;
        end else if (!slave_ack) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign wd_expired = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= '0;
            err_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req && dec_hit) begin
                sel <= dec_idx;
            end
            // Capture on entry so err_addr is valid alongside the bus_err pulse.
            if (state_nxt == DECERR || state_nxt == TOERR) begin
                err_addr <= cpu.adr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cpu.ack   = 1'b0;
        cpu.dat_i = '0;
        s_cyc     = '0;
        s_stb     = '0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = dec_hit ? ACTIVE : DECERR;
                end
            end
            ACTIVE: begin
                s_cyc[sel] = cpu.cyc;
                s_stb[sel] = cpu.stb;
                cpu.ack    = slave_ack;
                cpu.dat_i  = slv_dat[sel];
                if (!cpu.cyc || slave_ack) begin
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    state_nxt = TOERR;
                end
            end
            DECERR, TOERR: begin
                cpu.ack   = 1'b1;
                cpu.dat_i = DEFAULT_DATA;
                bus_err   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Randomised self-checking bench for wb_interconnect with a behavioural slave/map model.
module tb_wb_interconnect;

    localparam int NS  = 4;
    localparam int TMO = 8;
    localparam logic [31:0] DEF = 32'hDEADBEEF;
    localparam logic [NS*32-1:0] TB_BASE = {32'h20000000, 32'h00000010, 32'h00100000, 32'h00000000};
    localparam logic [NS*32-1:0] TB_MASK = {32'hF0000000, 32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFFF00};

    logic clk;
    logic rst;
    wb_interconnect_if cpu_if();

    logic [31:0]      s_adr;
    logic [31:0]      s_dat_o;
    logic             s_we;
    logic [NS-1:0]    s_cyc;
    logic [NS-1:0]    s_stb;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack;
    logic             bus_err;
    logic [31:0]      err_addr;

    wb_interconnect #(
        .NSLAVES        (NS),
        .SLAVE_BASE     (TB_BASE),
        .SLAVE_MASK     (TB_MASK),
        .DEFAULT_DATA   (DEF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_if),
        .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),
        .s_we     (s_we),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_dat_i  (s_dat_i),
        .s_ack    (s_ack),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: ACK after lat[i] waiting cycles, 16-word memory each.
    int            lat      [NS];
    int            wait_cnt [NS];
    logic [NS-1:0] late_ack;
    logic [31:0]   mem      [NS][16];

    function automatic logic [31:0] pat(input int s, input int w);
        return 32'hA5000000 | (32'(s) << 8) | 32'(w);
    endfunction

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_ack[i] = (s_cyc[i] & s_stb[i] & (wait_cnt[i] >= lat[i])) | late_ack[i];
            s_dat_i[i*32 +: 32] = mem[i][s_adr[5:2]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst) begin
                wait_cnt[i] <= 0;
                for (int w = 0; w < 16; w++) mem[i][w] <= pat(i, w);
            end else if (s_cyc[i] && s_stb[i]) begin
                if (s_ack[i]) begin
                    wait_cnt[i] <= 0;
                    if (s_we) mem[i][s_adr[5:2]] <= s_dat_o;
                end else begin
                    wait_cnt[i] <= wait_cnt[i] + 1;
                end
            end else begin
                wait_cnt[i] <= 0;
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [NS][16];
    logic [31:0] last_rd;
    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int decode_ref(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & TB_MASK[i*32 +: 32]) == TB_BASE[i*32 +: 32]) return i;
        end
        return -1;
    endfunction

    task automatic init_ref();
        for (int i = 0; i < NS; i++)
            for (int w = 0; w < 16; w++) ref_mem[i][w] = pat(i, w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one access from posedge+1 and check its outcome against the expectations given.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input int exp_slave, input bit exp_err, input int exp_cyc,
                             input logic [31:0] exp_dat, input bit chk_dat);
        int          n;
        int          errs;
        bit          got_ack;
        bit          leak;
        logic [NS-1:0] ok_mask;
        logic [NS-1:0] stb_at_ack;
        ok_mask = (exp_slave >= 0) ? (NS'(1) << exp_slave) : '0;
        cpu_if.adr = a; cpu_if.dat_o = d; cpu_if.we = w;
        cpu_if.cyc = 1'b1; cpu_if.stb = 1'b1;
        n = 0; errs = 0; got_ack = 1'b0; leak = 1'b0; stb_at_ack = '0;
        while (!got_ack && n < 64) begin
            @(negedge clk);
            n++;
            if (((s_stb | s_cyc) & ~ok_mask) != '0) leak = 1'b1;
            if (bus_err) errs++;
            if (cpu_if.ack) begin
                got_ack    = 1'b1;
                last_rd    = cpu_if.dat_i;
                stb_at_ack = s_stb;
            end
        end
        step();
        cpu_if.cyc = 1'b0; cpu_if.stb = 1'b0;
        check_eq("acked", 32'(got_ack), 32'd1);
        check_eq("latency", 32'(n), 32'(exp_cyc));
        check_eq("stb_leak", 32'(leak), 32'd0);
        check_eq("bus_err_pulses", 32'(errs), exp_err ? 32'd1 : 32'd0);
        if (chk_dat) check_eq("rdata", last_rd, exp_dat);
        if (exp_err) begin
            check_eq("err_addr", err_addr, a);
            check_eq("err_stb_off", 32'(stb_at_ack), 32'd0);
        end
    endtask

    // Compute expectations from the address map and slave behaviour, then run the access.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          s;
        bit          err;
        int          cyc;
        logic [31:0] ed;
        bit          cd;
        s = decode_ref(a);
        err = 1'b0; cyc = 2; ed = DEF; cd = 1'b1;
        if (s < 0) begin
            err = 1'b1;
        end else begin
`ifdef WB_INTERCONNECT_WATCHDOG_EN
            if (lat[s] >= TMO) begin
                err = 1'b1;
                cyc = 2 + TMO;
            end
`endif
            if (!err) begin
                cyc = 2 + lat[s];
                ed  = ref_mem[s][a[5:2]];
                cd  = !w;
                if (w) ref_mem[s][a[5:2]] = d;
            end
        end
        do_access(w, a, d, s, err, cyc, ed, cd);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w4;
        w4 = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 4))
            0:       return w4 | (32'($urandom_range(0, 3)) << 6);
            1:       return 32'h00100000 | w4 | (32'($urandom_range(0, 63)) << 6);
            2:       return 32'h20000000 | w4 | ($urandom & 32'h0FFFFFC0);
            3:       return 32'h00000010 | (w4 & 32'hC);
            default: return 32'h80000000 | ($urandom & 32'h3FFFFFFC);
        endcase
    endfunction

    initial begin
        bit ack_seen;
        n_checks = 0; n_fail = 0; last_rd = '0;
        late_ack = '0;
        for (int i = 0; i < NS; i++) lat[i] = 0;
        cpu_if.adr = '0; cpu_if.dat_o = '0; cpu_if.we = 1'b0;
        cpu_if.cyc = 1'b0; cpu_if.stb = 1'b0;
        init_ref();
        rst = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_ack", 32'(cpu_if.ack), 32'd0);
        check_eq("rst_dat_i", cpu_if.dat_i, 32'd0);
        check_eq("rst_s_cyc", 32'(s_cyc), 32'd0);
        check_eq("rst_s_stb", 32'(s_stb), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err), 32'd0);
        check_eq("rst_err_addr", err_addr, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Write then read slave 1 with a two-cycle slave latency.
        lat[1] = 0;
        run_access(1'b1, 32'h00100004, 32'h12345678);
        lat[1] = 2;
        run_access(1'b0, 32'h00100004, 32'h0);
        check_eq("slave1_read", last_rd, 32'h12345678);

        // Unmapped access.
        run_access(1'b0, 32'h80000000, 32'h0);
        check_eq("unmapped_data", last_rd, DEF);
        check_eq("unmapped_err_addr", err_addr, 32'h80000000);

        // Overlap: slave 0 beats slave 2.
        lat[0] = 1;
        run_access(1'b0, 32'h00000010, 32'h0);
        check_eq("overlap_data", last_rd, pat(0, 4));

        // Abort after one ACTIVE cycle, then a late slave ACK.
        lat[3] = 5;
        cpu_if.adr = 32'h20000040; cpu_if.we = 1'b0;
        cpu_if.cyc = 1'b1; cpu_if.stb = 1'b1;
        @(negedge clk);
        check_eq("abort_idle_stb", 32'(s_stb), 32'd0);
        @(negedge clk);
        check_eq("abort_active_stb", 32'(s_stb), 32'b1000);
        step();
        cpu_if.cyc = 1'b0; cpu_if.stb = 1'b0;
        late_ack[3] = 1'b1;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_if.ack || s_stb != '0) ack_seen = 1'b1;
        end
        late_ack = '0;
        step();
        check_eq("abort_no_ack", 32'(ack_seen), 32'd0);
        lat[3] = 1;
        run_access(1'b0, 32'h20000044, 32'h0);

`ifdef WB_INTERCONNECT_WATCHDOG_EN
        // Silent slave times out; an ACK in the last allowed cycle still wins.
        lat[0] = 1000;
        run_access(1'b0, 32'h00000004, 32'h0);
        check_eq("wd_data", last_rd, DEF);
        lat[0] = TMO - 1;
        run_access(1'b0, 32'h00000008, 32'h0);
        check_eq("wd_edge_data", last_rd, pat(0, 2));
`endif

        // Random traffic with random gaps and latencies.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < NS; i++) lat[i] = $urandom_range(0, 3);
            run_access(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset mid-ACTIVE.
        lat[1] = 50;
        cpu_if.adr = 32'h00100008; cpu_if.we = 1'b0;
        cpu_if.cyc = 1'b1; cpu_if.stb = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_eq("pre_rst_stb", 32'(s_stb), 32'b0010);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check_eq("midrst_s_stb", 32'(s_stb), 32'd0);
        check_eq("midrst_s_cyc", 32'(s_cyc), 32'd0);
        check_eq("midrst_ack", 32'(cpu_if.ack), 32'd0);
        check_eq("midrst_dat_i", cpu_if.dat_i, 32'd0);
        check_eq("midrst_bus_err", 32'(bus_err), 32'd0);
        check_eq("midrst_err_addr", err_addr, 32'd0);
        step();
        rst = 1'b1;
        cpu_if.cyc = 1'b0; cpu_if.stb = 1'b0;
        init_ref();
        step();
        lat[1] = 0;
        run_access(1'b0, 32'h00100008, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
